// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with internal TX FIFO
//
// Purpose : Serialises bytes from an internal FIFO onto o_tx. Frame format is
//           5-8 data bits, none/even/odd parity and 1 or 2 stop bits.
//           The format is captured at the start of each frame.
// Optional: `define UART_TX_BREAK_EN adds i_break and a BREAK / mark-after-break
//           sequence.
// Ports   : i_clk, i_reset (async, active-high), i_enable, i_baud_div,
//           i_data_bits, i_parity, i_stop2, i_write, i_data, [i_break],
//           o_ready, o_empty, o_count, o_overflow, o_active, o_tx
module uart_tx_cfg #(
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 16
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic [CNT_W-1:0]            i_baud_div,
   input  logic [1:0]                  i_data_bits,
   input  logic [1:0]                  i_parity,
   input  logic                        i_stop2,
   input  logic                        i_write,
   input  logic [7:0]                  i_data,
`ifdef UART_TX_BREAK_EN
   input  logic                        i_break,
`endif
   output logic                        o_ready,
   output logic                        o_empty,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_overflow,
   output logic                        o_active,
   output logic                        o_tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, MAB} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

   state_t        state;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          brk_req;

   logic [CNT_W-1:0] baud_cnt;
   logic [SW-1:0]    sample;
   logic             run;
   logic             tick;
   logic             bit_end;

   logic [7:0]    shreg;
   logic [1:0]    nbits;
   logic          par_en;
   logic          par_bit;
   logic          stop2;
   logic          stop_idx;
   logic [2:0]    bit_idx;
   logic [2:0]    last_idx;
   logic [7:0]    fifo_rd;
   logic [7:0]    data_mask;
   logic          par_calc;

`ifdef UART_TX_BREAK_EN
   assign brk_req = i_break;
`else
   assign brk_req = 1'b0;
`endif

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push    = i_write && !full;
   assign pop     = (state == IDLE) && i_enable && !empty && !brk_req;
   assign o_ready = !full;
   assign o_empty = empty;
   assign o_count = count;

   // Parity is computed from the popped byte when it is latched, so only the
   // bits that will actually be sent contribute.
   assign fifo_rd   = mem[rd_ptr];
   assign data_mask = 8'hFF >> (2'd3 - i_data_bits);
   assign par_calc  = (^(fifo_rd & data_mask)) ^ (i_parity == 2'b10);
   assign last_idx  = {1'b0, nbits} + 3'd4;

   // Baud ticks only run inside timed states; IDLE (and BREAK) hold the
   // divider at 0 so every frame starts with a fresh bit period.
   always_comb begin
      run = i_enable && (state != IDLE);
`ifdef UART_TX_BREAK_EN
      if (state == BRK) run = 1'b0;
`endif
   end

   assign tick    = run && (baud_cnt == i_baud_div);
   assign bit_end = tick && (sample == OS_LAST);

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= i_write && full;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         baud_cnt <= '0;
      end else if (!run || (baud_cnt == i_baud_div)) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         o_tx     <= 1'b1;
         o_active <= 1'b0;
         sample   <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         nbits    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2    <= 1'b0;
      end else if (!i_enable) begin
         // Abort: the frame in flight is dropped, FIFO is untouched.
         state    <= IDLE;
         o_tx     <= 1'b1;
         o_active <= 1'b0;
         sample   <= '0;
      end else begin
         if (tick) sample <= (sample == OS_LAST) ? '0 : sample + 1'b1;
         case (state)
            IDLE: begin
               sample   <= '0;
               o_tx     <= 1'b1;
               o_active <= 1'b0;
               if (brk_req) begin
`ifdef UART_TX_BREAK_EN
                  state    <= BRK;
                  o_tx     <= 1'b0;
                  o_active <= 1'b1;
`endif
               end else if (!empty) begin
                  state    <= START;
                  o_tx     <= 1'b0;
                  o_active <= 1'b1;
                  shreg    <= fifo_rd;
                  nbits    <= i_data_bits;
                  par_en   <= (i_parity == 2'b01) || (i_parity == 2'b10);
                  par_bit  <= par_calc;
                  stop2    <= i_stop2;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  o_tx    <= shreg[0];
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == last_idx) begin
                     if (par_en) begin
                        state <= PARITY;
                        o_tx  <= par_bit;
                     end else begin
                        state    <= STOP;
                        o_tx     <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     o_tx    <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  o_tx     <= 1'b1;
                  stop_idx <= 1'b0;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (stop2 && !stop_idx) begin
                     stop_idx <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     o_active <= 1'b0;
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
               if (!i_break) begin
                  state <= MAB;
                  o_tx  <= 1'b1;
               end
            end
            MAB: begin
               if (bit_end) begin
                  state    <= IDLE;
                  o_active <= 1'b0;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               o_tx     <= 1'b1;
               o_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

   localparam int OS    = 16;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] div;
   logic [1:0]  db;
   logic [1:0]  par;
   logic        s2;
   logic        wr;
   logic [7:0]  din;
`ifdef UART_TX_BREAK_EN
   logic        brk;
`endif
   logic        ready;
   logic        empty;
   logic [4:0]  count;
   logic        ovf;
   logic        active;
   logic        tx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .CNT_W(16)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_enable(en),
      .i_baud_div(div),
      .i_data_bits(db),
      .i_parity(par),
      .i_stop2(s2),
      .i_write(wr),
      .i_data(din),
`ifdef UART_TX_BREAK_EN
      .i_break(brk),
`endif
      .o_ready(ready),
      .o_empty(empty),
      .o_count(count),
      .o_overflow(ovf),
      .o_active(active),
      .o_tx(tx)
   );

   typedef struct {
      logic [1:0]  db;
      logic [1:0]  par;
      logic        s2;
      logic [15:0] div;
      logic [7:0]  data;
      logic        has_par;
      logic        exp_par;
      int          exp_nbits;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference frame: list of line levels, one per bit period, in time order.
   function automatic int frame_bits(input logic [7:0] d, input logic [1:0] dbits,
                                     input logic [1:0] p, input logic st2,
                                     output logic [15:0] b);
      int n, k, ones;
      b = '1;
      n = int'(dbits) + 5;
      k = 0;
      ones = 0;
      b[k] = 1'b0; k++;
      for (int i = 0; i < n; i++) begin
         b[k] = d[i];
         ones += int'(d[i]);
         k++;
      end
      if (p == 2'b01) begin b[k] = (ones % 2 == 1); k++; end
      else if (p == 2'b10) begin b[k] = (ones % 2 == 0); k++; end
      b[k] = 1'b1; k++;
      if (st2) begin b[k] = 1'b1; k++; end
      return k;
   endfunction

   task automatic run_vec(input vec_t v);
      logic [15:0] b;
      int nb, len, i, mism, pi;
      logic psample;
      nb = frame_bits(v.data, v.db, v.par, v.s2, b);
      len = OS * (int'(v.div) + 1);
      pi = int'(v.db) + 6;
      psample = 1'bx;
      db = v.db; par = v.par; s2 = v.s2; div = v.div; din = v.data; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      check("lat_still_idle", tx, 1);
      mism = 0;
      i = 0;
      while (i < 12 * len + 4) begin
         @(negedge clk);
         if (active !== 1'b1) break;
         if (i < nb * len && tx !== b[i / len]) mism++;
         if (i == pi * len + len / 2) psample = tx;
         i++;
      end
      check("frame_len", i, v.exp_nbits * len);
      check("frame_wave", mism, 0);
      check("end_idle_tx", tx, 1);
      if (v.has_par) check("parity_bit", psample, v.exp_par);
   endtask

   initial begin
      logic [7:0]  q[16];
      logic [15:0] b;
      int nb, len, mism, ovf_bad, n;

      vecs[0] = '{2'd3, 2'b00, 1'b0, 16'd0, 8'hA5, 1'b0, 1'b0, 10};
      vecs[1] = '{2'd2, 2'b01, 1'b1, 16'd0, 8'hFF, 1'b1, 1'b1, 11};
      vecs[2] = '{2'd2, 2'b01, 1'b1, 16'd0, 8'h03, 1'b1, 1'b0, 11};
      vecs[3] = '{2'd0, 2'b10, 1'b0, 16'd0, 8'h00, 1'b1, 1'b1, 8};
      vecs[4] = '{2'd0, 2'b10, 1'b0, 16'd0, 8'hE1, 1'b1, 1'b0, 8};
      vecs[5] = '{2'd3, 2'b11, 1'b1, 16'd1, 8'h5A, 1'b0, 1'b0, 11};
      vecs[6] = '{2'd1, 2'b10, 1'b0, 16'd2, 8'h3C, 1'b1, 1'b1, 9};

      rst = 1'b1; en = 1'b0; div = '0; db = 2'd3; par = 2'b00; s2 = 1'b0;
      wr = 1'b0; din = '0;
`ifdef UART_TX_BREAK_EN
      brk = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_active", active, 0);
      check("rst_ovf", ovf, 0);
      check("rst_empty", empty, 1);
      check("rst_ready", ready, 1);
      check("rst_count", count, 0);
      rst = 1'b0;
      en = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) run_vec(vecs[v]);

      // Fill while disabled, overflow on the 17th write, then drain back-to-back.
      en = 1'b0;
      db = 2'($urandom_range(0, 3));
      par = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      div = 16'($urandom_range(0, 1));
      ovf_bad = 0;
      for (int w = 0; w < 17; w++) begin
         din = 8'($urandom);
         if (w < 16) q[w] = din;
         wr = 1'b1;
         @(negedge clk);
         if (w < 16 && ovf) ovf_bad++;
         if (w == 14) check("ready_at_15", ready, 1);
         if (w == 15) begin
            check("ready_full", ready, 0);
            check("count_full", count, 16);
         end
         if (w == 16) check("ovf_pulse", ovf, 1);
      end
      wr = 1'b0;
      @(negedge clk);
      check("ovf_one_cycle", ovf, 0);
      check("ovf_early", ovf_bad, 0);
      check("count_after_drop", count, 16);
      check("idle_while_disabled", active, 0);
      en = 1'b1;
      len = OS * (int'(div) + 1);
      mism = 0;
      for (int f = 0; f < 16; f++) begin
         nb = frame_bits(q[f], db, par, s2, b);
         for (int i = 0; i < nb * len; i++) begin
            @(negedge clk);
            if (tx !== b[i / len] || active !== 1'b1) mism++;
         end
         @(negedge clk);
         if (tx !== 1'b1 || active !== 1'b0) mism++;
      end
      check("b2b_wave", mism, 0);
      check("b2b_empty", empty, 1);
      check("b2b_count", count, 0);

      // Disable mid-DATA, then reset mid-frame.
      en = 1'b0; db = 2'd3; par = 2'b00; s2 = 1'b0; div = '0; din = 8'h00;
      wr = 1'b1;
      repeat (3) @(negedge clk);
      wr = 1'b0;
      en = 1'b1;
      @(negedge clk);
      check("abort_start", count, 2);
      repeat (40) @(negedge clk);
      check("mid_data_low", tx, 0);
      en = 1'b0;
      @(negedge clk);
      check("dis_tx", tx, 1);
      check("dis_active", active, 0);
      check("dis_count", count, 2);
      en = 1'b1;
      @(negedge clk);
      check("reen_start", {active, tx}, 2'b10);
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx", tx, 1);
      check("async_rst_count", count, 0);
      check("async_rst_active", active, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

`ifdef UART_TX_BREAK_EN
      en = 1'b1; db = 2'd3; par = 2'b00; s2 = 1'b0; div = '0;
      din = 8'h55; wr = 1'b1;
      @(negedge clk);
      din = 8'h0F;
      @(negedge clk);
      wr = 1'b0;
      n = 0;
      repeat (20) @(negedge clk);
      brk = 1'b1;
      n = 20;
      while (active === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("brk_frame_len", n, 10 * OS);
      @(negedge clk);
      check("brk_enter", {active, tx}, 2'b10);
      mism = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b0) mism++;
      end
      check("brk_hold_low", mism, 0);
      brk = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) break;
         n++;
      end
      check("mab_len", n, OS + 1);
      check("brk_next_pop", count, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Configurable UART transmitter with an internal TX FIFO. It is the successor to the fixed 8N1 transmitter in the peripherals tree.
- Frame format is selected at run time: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Oversample ratio and FIFO depth are parameters.
- Sits behind the UART register block; the CPU writes bytes, and the block serialises them on o_tx.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, >= 2
OVERSAMPLE, 16, baud ticks per bit period; 4..64
CNT_W, 16, width of the baud divisor

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-high
i_enable  in  1  transmitter enable
i_baud_div  in  CNT_W  baud tick every (i_baud_div+1) clocks
i_data_bits  in  2  data bits: 0=5, 1=6, 2=7, 3=8
i_parity  in  2  00=none, 01=even, 10=odd, 11=none
i_stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits
i_write  in  1  push i_data into the FIFO
i_data  in  8  byte to send; bits above the data width are ignored
o_ready  out  1  FIFO not full
o_empty  out  1  FIFO empty
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_overflow  out  1  one-cycle pulse when a write is dropped
o_active  out  1  frame in progress (state != IDLE)
o_tx  out  1  serial line, idle high

Behaviour:
- Reset values: o_tx=1, o_active=0, o_overflow=0, o_empty=1, o_ready=1, o_count=0; state IDLE; all counters 0.
- Baud generator: counter 0..i_baud_div, then wraps to 0; the one-cycle tick asserts on the wrap. While !i_enable the counter is held at 0 with no ticks.
- Bit timing: each serial bit lasts exactly OVERSAMPLE ticks, i.e. OVERSAMPLE*(i_baud_div+1) clocks.
- FIFO write:
  - accepted when i_write && !full;
  - when i_write && full, the data is dropped and o_overflow pulses for 1 cycle;
  - full is evaluated before any same-cycle pop.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START:
  - Condition: i_enable && !empty; checked every clock, not only on ticks.
  - Same cycle: pop the FIFO; latch the byte, i_data_bits, i_parity and i_stop2 into frame registers.
  - Next cycle: o_tx=0; the sample and baud counters restart at 0.
  - Latency from i_write into an empty idle FIFO to o_tx falling: 2 clocks.
- START -> DATA after OVERSAMPLE ticks.
- DATA: LSB first; sends (latched data_bits+5) bits.
- After the last data bit: go to PARITY if the latched parity is 01 or 10, else to STOP.
- PARITY bit value:
  - even: XOR of the transmitted data bits;
  - odd: the inverse of that.
- STOP: o_tx=1 for 1 or 2 bit periods (latched i_stop2), then IDLE.
- Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next START follows with no extra idle bit. The IDLE cycle is a single clock.
- Config changes mid-frame have no effect until the next frame.
- i_enable deasserted mid-frame:
  - next cycle: state IDLE, o_tx=1;
  - the current byte is lost;
  - FIFO contents are retained.
- i_reset mid-frame: immediate return to reset values; the FIFO is emptied.
- o_active is high from the START cycle through the last STOP clock inclusive.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port i_break (1 bit).
  - When i_break=1 and the FSM reaches IDLE, the block enters a BREAK state: o_tx=0, o_active=1, no FIFO pop.
  - A frame in progress completes before BREAK is entered.
  - On i_break falling: o_tx=1 and hold for one full bit period (mark-after-break), then IDLE.
  - i_break=1 while i_enable=0 has no effect.
- Undefined: no i_break port, no BREAK state; behaviour is identical to the above with i_break=0.

Test Plan:
- div=0, OVERSAMPLE=16, 8N1, write 0xA5 -> o_tx low 2 clocks after the write; bits 1,0,1,0,0,1,0,1 LSB first, 16 clocks each; stop high; o_active high for 160 clocks.
- 7 data bits, even parity, 2 stop bits, write 0xFF -> 7 ones, parity 1, 32 clocks of stop; 0x03 -> parity 0.
- 5 data bits, odd parity, write 0x00 -> 5 zeros, parity 1; write 0xE1 -> data 1,0,0,0,0 (bits 7:5 ignored), parity 0.
- Disabled, write 17 bytes into FIFO_DEPTH=16 -> o_ready=0 after 16 writes, o_overflow pulses on write 17, o_count=16; then enable -> 16 frames back-to-back, no gaps, o_empty=1 at the end.
- Disable mid-DATA -> o_tx=1 next cycle, o_active=0, o_count unchanged; assert i_reset mid-frame -> o_tx=1 and o_count=0 immediately, without waiting for a clock edge.
- [UART_TX_BREAK_EN] assert i_break during a frame -> the frame completes, then o_tx=0 until release, then 1 bit period high, then the next FIFO byte.
